// File: rtl/ce_psum_accum.sv
// ce_psum_accum: accumulates NPASS signed partial sums from the CE stage into
// one result, adds a per-group bias, then shifts, optionally ReLUs and
// saturates it to OUT_W bits with a one-cycle valid pulse.
// Build option: define CE_PSUM_ROUND_EN to round half up before the shift
// (default build truncates).
module ce_psum_accum #(
    parameter int IN_W  = 17,
    parameter int NPASS = 4,
    parameter int ACC_W = 24,
    parameter int SR    = 2,
    parameter int OUT_W = 8,
    parameter int RELU  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  d_in,
    input  logic             en_in,
    input  logic [ACC_W-1:0] bias,
    input  logic             clr,
    output logic [OUT_W-1:0] d_out,
    output logic             en_out,
    output logic             sat_out,
    output logic             busy
);

    localparam int CNT_W = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPASS - 1);
    localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 2;

    // Output range limits, widened so any shifted accumulator value compares cleanly
    localparam logic signed [EXT_W-1:0] L_UMAX = {{(EXT_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    localparam logic signed [EXT_W-1:0] L_SMAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] L_SMIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

`ifdef CE_PSUM_ROUND_EN
    // Half an LSB of the shifted result; zero when there is no shift
    localparam logic signed [ACC_W:0] ROUND_ADD = (ACC_W+1)'((2 ** SR) / 2);
    localparam logic signed [ACC_W:0] ACC_MAX_X = {2'b00, {(ACC_W-1){1'b1}}};
`endif

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic                     w_done_nxt;
    logic                     w_acc_ld;
    logic                     w_acc_first;
    logic signed [ACC_W-1:0]  w_din_ext;
    logic signed [ACC_W-1:0]  w_shifted;
    logic [OUT_W:0]           w_sat_res;
    logic signed [ACC_W-1:0]  r_acc_p0;
    logic                     r_vld_p0;
    logic [OUT_W-1:0]         r_dout_p1;
    logic                     r_vld_p1;
    logic                     r_sat_p1;

    function automatic logic signed [ACC_W-1:0] f_round(input logic signed [ACC_W-1:0] a);
`ifdef CE_PSUM_ROUND_EN
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + ROUND_ADD;
        if (s > ACC_MAX_X)
            return ACC_MAX_X[ACC_W-1:0];
        return s[ACC_W-1:0];
`else
        return a;
`endif
    endfunction

    // Returns {sat_flag, clipped_value}
    function automatic logic [OUT_W:0] f_sat(input logic signed [ACC_W-1:0] v);
        logic signed [EXT_W-1:0] x;
        x = {{(EXT_W-ACC_W){v[ACC_W-1]}}, v};
        if (RELU != 0) begin
            if (x[EXT_W-1])
                return '0;
            else if (x > L_UMAX)
                return {1'b1, {OUT_W{1'b1}}};
            else
                return {1'b0, x[OUT_W-1:0]};
        end else begin
            if (x > L_SMAX)
                return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
            else if (x < L_SMIN)
                return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
            else
                return {1'b0, x[OUT_W-1:0]};
        end
    endfunction

    assign w_din_ext = {{(ACC_W-IN_W){d_in[IN_W-1]}}, d_in};
    assign w_shifted = f_round(r_acc_p0) >>> SR;
    assign w_sat_res = f_sat(w_shifted);

    // Pass sequencing: clr aborts the group, en_in advances or wraps the pass counter
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_acc_ld    = 1'b0;
        w_acc_first = 1'b0;
        if (clr) begin
            w_cnt_nxt = '0;
        end else if (en_in) begin
            w_acc_ld    = 1'b1;
            w_acc_first = (r_state == S_IDLE);
            if (r_cnt == CNT_LAST) begin
                w_cnt_nxt  = '0;
                w_done_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
        w_state_nxt = (w_cnt_nxt != '0) ? S_ACCUM : S_IDLE;
    end

    // Control state: pass counter, FSM state and the group-complete strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_vld_p0 <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_vld_p0 <= w_done_nxt;
        end
    end

    // Stage 0: accumulator, seeded with the bias on the first pass of a group
    always_ff @(posedge clk) begin
        if (rst)
            r_acc_p0 <= '0;
        else if (w_acc_ld)
            r_acc_p0 <= w_acc_first ? ($signed(bias) + w_din_ext) : (r_acc_p0 + w_din_ext);
    end

    // Stage 1: registered result; a pending completion dropped by clr never reaches here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout_p1 <= '0;
            r_vld_p1  <= 1'b0;
            r_sat_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= r_vld_p0 && !clr;
            r_sat_p1 <= r_vld_p0 && !clr && w_sat_res[OUT_W];
            if (r_vld_p0 && !clr)
                r_dout_p1 <= w_sat_res[OUT_W-1:0];
        end
    end

    assign d_out   = r_dout_p1;
    assign en_out  = r_vld_p1;
    assign sat_out = r_sat_p1;
    assign busy    = (r_cnt != '0);

endmodule

// File: tb/tb_ce_psum_accum.sv
// Directed bench for ce_psum_accum: default instance (ReLU) and a signed-output
// instance share the same stimulus; expected values are worked out by hand.
module tb_ce_psum_accum;

    localparam int IN_W  = 17;
    localparam int ACC_W = 24;
    localparam int OUT_W = 8;

`ifdef CE_PSUM_ROUND_EN
    localparam int EXP_RND = 26;
`else
    localparam int EXP_RND = 25;
`endif

    logic             clk;
    logic             rst;
    logic [IN_W-1:0]  d_in;
    logic             en_in;
    logic [ACC_W-1:0] bias;
    logic             clr;
    logic [OUT_W-1:0] d_out_a, d_out_b;
    logic             en_out_a, en_out_b;
    logic             sat_out_a, sat_out_b;
    logic             busy_a, busy_b;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses;

    ce_psum_accum dut_a (
        .clk(clk), .rst(rst), .d_in(d_in), .en_in(en_in), .bias(bias), .clr(clr),
        .d_out(d_out_a), .en_out(en_out_a), .sat_out(sat_out_a), .busy(busy_a)
    );

    ce_psum_accum #(.RELU(0)) dut_b (
        .clk(clk), .rst(rst), .d_in(d_in), .en_in(en_in), .bias(bias), .clr(clr),
        .d_out(d_out_b), .en_out(en_out_b), .sat_out(sat_out_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then move to just after the sampling edge
    task automatic cyc(input logic e, input int d, input logic c);
        logic [31:0] dv;
        dv    = d;
        en_in = e;
        d_in  = dv[IN_W-1:0];
        clr   = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] bv;
        rst   = 1'b1;
        en_in = 1'b0;
        d_in  = '0;
        bias  = '0;
        clr   = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("rst_dout", 32'(d_out_a), 0);
        chk("rst_en", 32'(en_out_a), 0);
        chk("rst_sat", 32'(sat_out_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        rst = 1'b0;
        cyc(0, 0, 0);

        // 10+20+30+40 = 100, >>>2 = 25, valid two cycles after the last pass
        cyc(1, 10, 0);
        chk("busy_accum", 32'(busy_a), 1);
        cyc(1, 20, 0);
        cyc(1, 30, 0);
        cyc(1, 40, 0);
        chk("lat_no_early", 32'(en_out_a), 0);
        chk("busy_wrap", 32'(busy_a), 0);
        cyc(0, 0, 0);
        chk("acc_en", 32'(en_out_a), 1);
        chk("acc_dout", 32'(d_out_a), 25);
        chk("acc_sat", 32'(sat_out_a), 0);
        chk("acc_dout_s", 32'(d_out_b), 25);
        cyc(0, 0, 0);
        chk("acc_pulse_end", 32'(en_out_a), 0);
        chk("acc_hold", 32'(d_out_a), 25);

        // -400 >>> 2 = -100: ReLU gives 0 unsaturated, signed gives 0x9C
        for (int i = 0; i < 4; i++) cyc(1, -100, 0);
        cyc(0, 0, 0);
        chk("neg_en", 32'(en_out_a), 1);
        chk("neg_dout", 32'(d_out_a), 0);
        chk("neg_sat", 32'(sat_out_a), 0);
        chk("neg_dout_s", 32'(d_out_b), 156);
        chk("neg_sat_s", 32'(sat_out_b), 0);

        // 4000 >>> 2 = 1000: clips to 255 / 127
        for (int i = 0; i < 4; i++) cyc(1, 1000, 0);
        cyc(0, 0, 0);
        chk("big_dout", 32'(d_out_a), 255);
        chk("big_sat", 32'(sat_out_a), 1);
        chk("big_dout_s", 32'(d_out_b), 127);
        chk("big_sat_s", 32'(sat_out_b), 1);
        cyc(0, 0, 0);
        chk("sat_pulse_end", 32'(sat_out_a), 0);

        // bias 2 + 4*25 = 102; later bias values must be ignored
        bias = 24'd2;
        cyc(1, 25, 0);
        bias = 24'd99;
        for (int i = 0; i < 3; i++) cyc(1, 25, 0);
        bias = '0;
        cyc(0, 0, 0);
        chk("rnd_en", 32'(en_out_a), 1);
        chk("rnd_dout", 32'(d_out_a), EXP_RND);
        chk("rnd_dout_s", 32'(d_out_b), EXP_RND);

        // Back-to-back: 4x4 -> 4, then bias -4 + 4x12 = 44 -> 11
        for (int i = 0; i < 8; i++) begin
            bv = (i >= 4) ? -32'sd4 : 32'd0;
            bias = bv[ACC_W-1:0];
            cyc(1, (i < 4) ? 4 : 12, 0);
            chk("b2b_en", 32'(en_out_a), (i == 4) ? 1 : 0);
            if (i == 4) chk("b2b_dout1", 32'(d_out_a), 4);
        end
        bias = '0;
        cyc(0, 0, 0);
        chk("b2b_en2", 32'(en_out_a), 1);
        chk("b2b_dout2", 32'(d_out_a), 11);

        // Abort: two passes, clr with en_in (value dropped), then a clean group of 8s
        pulses = 0;
        cyc(1, 8, 0);
        cyc(1, 8, 0);
        pulses += int'(en_out_a);
        cyc(1, 100, 1);
        chk("clr_busy", 32'(busy_a), 0);
        for (int i = 0; i < 6; i++) begin
            cyc((i < 4) ? 1'b1 : 1'b0, 8, 0);
            pulses += int'(en_out_a);
            if (i == 5) chk("clr_dout", 32'(d_out_a), 8);
        end
        chk("clr_pulses", 32'(pulses), 1);

        // clr in the cycle after the last pass drops the pending result
        for (int i = 0; i < 4; i++) cyc(1, 20, 0);
        cyc(0, 0, 1);
        chk("clr_pend_en", 32'(en_out_a), 0);
        chk("clr_pend_hold", 32'(d_out_a), 8);
        cyc(0, 0, 0);
        chk("clr_pend_en2", 32'(en_out_a), 0);

        // Reset after pass 3 of 4, with a competing en_in
        for (int i = 0; i < 3; i++) cyc(1, 8, 0);
        rst = 1'b1;
        cyc(1, 50, 0);
        rst = 1'b0;
        chk("mrst_dout", 32'(d_out_a), 0);
        chk("mrst_en", 32'(en_out_a), 0);
        chk("mrst_sat", 32'(sat_out_a), 0);
        chk("mrst_busy", 32'(busy_a), 0);
        cyc(1, 8, 0);
        chk("mrst_busy1", 32'(busy_a), 1);
        cyc(1, 40, 0);
        chk("mrst_no_en", 32'(en_out_a), 0);
        cyc(1, 40, 0);
        cyc(1, 40, 0);
        chk("mrst_no_en2", 32'(en_out_a), 0);
        cyc(0, 0, 0);
        chk("mrst_en_out", 32'(en_out_a), 1);
        chk("mrst_dout2", 32'(d_out_a), 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ce_psum_accum.md
CE_PSUM_ACCUM -- requirements
Module: ce_psum_accum

Interface
REQ-001 SHALL have parameter IN_W, default 17, giving the width of the partial-sum input (matches the CE output width).
REQ-002 SHALL have parameter NPASS, default 4, the number of partial sums per output (1..64).
REQ-003 SHALL have parameter ACC_W, default 24, the signed accumulator width; it SHALL be at least IN_W+clog2(NPASS)+1.
REQ-004 SHALL have parameter SR, default 2, the arithmetic right shift applied before output (0..8).
REQ-005 SHALL have parameter OUT_W, default 8, the output data width.
REQ-006 SHALL have parameter RELU, default 1: 1 clamps negatives to 0; 0 gives signed output.
REQ-007 SHALL have port clk, input, 1 bit: the only clock; all logic updates on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port d_in, input, IN_W bits: a two's-complement partial sum from the CE stage.
REQ-010 SHALL have port en_in, input, 1 bit: d_in is valid this cycle.
REQ-011 SHALL have port bias, input, ACC_W bits: a signed bias, sampled only on the first pass of a group.
REQ-012 SHALL have port clr, input, 1 bit: a synchronous abort of the current group.
REQ-013 SHALL have port d_out, output, OUT_W bits: the result, registered.
REQ-014 SHALL have port en_out, output, 1 bit: a one-cycle pulse marking d_out valid.
REQ-015 SHALL have port sat_out, output, 1 bit: the result was saturated; valid together with en_out.
REQ-016 SHALL have port busy, output, 1 bit: a group is partially accumulated (state ACCUM).

Function
REQ-017 SHALL sign-extend d_in to ACC_W bits before any addition.
REQ-018 SHALL keep a pass counter cnt in 0..NPASS-1 and two states:
- IDLE: cnt==0.
- ACCUM: cnt>0.
REQ-019 SHALL, on en_in with cnt==0, load acc with bias+d_in.
REQ-020 SHALL, on en_in with cnt>0, load acc with acc+d_in; acc wraps modulo 2^ACC_W.
REQ-021 SHALL, on en_in with cnt==NPASS-1, return cnt to 0 and set the internal flag done for one cycle; otherwise en_in SHALL increment cnt.
REQ-022 SHALL, in the cycle after done, register d_out=sat(relu(acc>>>SR)) together with en_out=1 and sat_out.
- Latency: the final en_in in cycle T gives en_out in cycle T+2.
REQ-023 SHALL saturate the output as follows:
- RELU=1: unsigned range 0..2^OUT_W-1; a negative value gives 0 with sat_out=0.
- RELU=0: signed range -2^(OUT_W-1)..2^(OUT_W-1)-1.
- sat_out SHALL be 1 only when clipping occurs at the range limits.
REQ-024 SHALL accept en_in on every cycle with no stall. A new group starting in cycle T+1 SHALL NOT corrupt the result being output from the previous group.
REQ-025 SHALL treat NPASS=1 as: every en_in loads bias+d_in and asserts done.
REQ-026 SHALL, on clr, force cnt to 0 and suppress any pending done; clr SHALL NOT affect an en_out already registered.
REQ-027 SHALL give clr priority over en_in in the same cycle; that d_in is discarded.
REQ-028 SHALL hold d_out between pulses and keep en_out and sat_out at 0 outside pulses.
REQ-029 SHALL drive busy as (cnt!=0).

Reset
REQ-030 SHALL, on rst, clear cnt, acc, done, d_out, en_out, sat_out and busy to 0 on the next rising edge.
REQ-031 SHALL, on rst asserted mid-group, discard the partial group; no en_out SHALL result from it.
REQ-032 SHALL give rst priority over clr and en_in.

Configuration
REQ-033 SHALL support the macro CE_PSUM_ROUND_EN.
- Defined: before the shift, add 2^(SR-1) to acc (round half up), saturating at the ACC_W signed maximum.
- Undefined: plain truncating arithmetic shift.
- With SR=0 both builds SHALL be identical.

Verification
REQ-034 SHALL cover accumulate and shift (defaults, bias=0): en_in with d_in 10,20,30,40 in cycles 0..3 -> d_out=25, en_out=1 in cycle 5, sat_out=0.
REQ-035 SHALL cover ReLU and saturation:
- d_in -100 x4 -> d_out=0, sat_out=0.
- d_in 1000 x4 -> d_out=255, sat_out=1.
- RELU=0 with d_in 1000 x4 -> d_out=127, sat_out=1.
REQ-036 SHALL cover rounding: bias=2, d_in 25,25,25,25 (acc=102):
- with CE_PSUM_ROUND_EN -> d_out=26.
- without it -> d_out=25.
REQ-037 SHALL cover back-to-back groups: 8 consecutive en_in of value 4 -> en_out pulses in cycles 5 and 9, each d_out=4.
REQ-038 SHALL cover abort: 2 passes, then clr concurrent with en_in, then 4 passes of 8 -> exactly one en_out, d_out=8.
REQ-039 SHALL cover reset mid-group: rst after pass 3 of 4 -> no en_out, all outputs 0, busy=0; the next full group then outputs correctly.
